// File: rtl/bp_fe_bp_update_queue_pkg.sv
// Shared types and defaults for the branch-predictor update queue.
// The entry layout is built by macros so that each instantiating module can size it from its own parameters.
// The macro BP_FE_BP_UPDATE_BYPASS_EN, when defined, enables the empty-queue bypass path in the top module.

`define BP_FE_DECLARE_BRANCH_METADATA_FWD_S(btb_w, bht_w, ras_w) \
   typedef struct packed { \
      logic [btb_w-1:0] btb_indx; \
      logic [bht_w-1:0] bht_indx; \
      logic [ras_w-1:0] ras_addr; \
   } bp_fe_branch_metadata_fwd_s;

`define BP_FE_DECLARE_BP_UPDATE_S(eaddr_w, btb_w, bht_w, ras_w) \
   `BP_FE_DECLARE_BRANCH_METADATA_FWD_S(btb_w, bht_w, ras_w) \
   typedef struct packed { \
      logic                       attaboy; \
      logic [eaddr_w-1:0]         target; \
      bp_fe_branch_metadata_fwd_s metadata; \
   } bp_fe_bp_update_s;

package bp_fe_bp_update_queue_pkg;

   localparam int unsigned eaddr_width_dflt    = 39;
   localparam int unsigned btb_indx_width_dflt = 9;
   localparam int unsigned bht_indx_width_dflt = 5;
   localparam int unsigned ras_addr_width_dflt = 2;
   localparam int unsigned els_dflt            = 4;

   // Total width of the forwarded branch metadata.
   function automatic int unsigned mdata_width(input int unsigned btb_w,
                                               input int unsigned bht_w,
                                               input int unsigned ras_w);
      return btb_w + bht_w + ras_w;
   endfunction

   localparam int unsigned mdata_width_dflt =
      mdata_width(btb_indx_width_dflt, bht_indx_width_dflt, ras_addr_width_dflt);

endpackage

// File: rtl/bp_fe_bp_update_queue_if.sv
// Backend update handshake plus predictor write port, bundled as one interface.
// master = backend/predictor side, slave = update queue.

interface bp_fe_bp_update_queue_if
   import bp_fe_bp_update_queue_pkg::*;
 #(parameter int unsigned eaddr_width_p = eaddr_width_dflt,
   parameter int unsigned mdata_width_p = mdata_width_dflt)
   ();

   logic                     upd_v_i;
   logic                     upd_ready_o;
   logic                     upd_attaboy_i;
   logic [eaddr_width_p-1:0] upd_target_i;
   logic [mdata_width_p-1:0] upd_metadata_i;

   logic                     drain_en_i;
   logic                     w_v_o;
   logic                     attaboy_o;
   logic [eaddr_width_p-1:0] pc_cmd_o;
   logic [mdata_width_p-1:0] branch_metadata_fwd_o;

   modport master (
      output upd_v_i, upd_attaboy_i, upd_target_i, upd_metadata_i, drain_en_i,
      input  upd_ready_o, w_v_o, attaboy_o, pc_cmd_o, branch_metadata_fwd_o
   );

   modport slave (
      input  upd_v_i, upd_attaboy_i, upd_target_i, upd_metadata_i, drain_en_i,
      output upd_ready_o, w_v_o, attaboy_o, pc_cmd_o, branch_metadata_fwd_o
   );

endinterface

// File: rtl/bp_fe_bp_update_mem.sv
// els_p x width_p register array: synchronous write, asynchronous read. Contents are not reset.

module bp_fe_bp_update_mem
 #(parameter int unsigned els_p   = 4,
   parameter int unsigned width_p = 56)
  (input  logic                       clk_i,
   input  logic                       w_v_i,
   input  logic [$clog2(els_p)-1:0]   w_addr_i,
   input  logic [width_p-1:0]         w_data_i,
   input  logic [$clog2(els_p)-1:0]   r_addr_i,
   output logic [width_p-1:0]         r_data_o);

   logic [width_p-1:0] mem [els_p];

   // Write port.
   always_ff @(posedge clk_i) begin
      if (w_v_i) mem[w_addr_i] <= w_data_i;
   end

   assign r_data_o = mem[r_addr_i];

endmodule

// File: rtl/bp_fe_bp_update_queue.sv
// Queue of resolved-branch feedback drained one entry per cycle into the branch predictor write port.
// Optional feature: define BP_FE_BP_UPDATE_BYPASS_EN to pass an update straight through when the queue is empty.

module bp_fe_bp_update_queue
   import bp_fe_bp_update_queue_pkg::*;
 #(parameter int unsigned eaddr_width_p    = eaddr_width_dflt,
   parameter int unsigned btb_indx_width_p = btb_indx_width_dflt,
   parameter int unsigned bht_indx_width_p = bht_indx_width_dflt,
   parameter int unsigned ras_addr_width_p = ras_addr_width_dflt,
   parameter int unsigned els_p            = els_dflt)
  (input  logic                     clk_i,
   input  logic                     reset_n_i,
   input  logic                     flush_i,
   bp_fe_bp_update_queue_if.slave   bus,
   output logic [$clog2(els_p):0]   count_o);

   localparam int unsigned ptr_width_lp = $clog2(els_p);
   localparam int unsigned cnt_width_lp = ptr_width_lp + 1;

   `BP_FE_DECLARE_BP_UPDATE_S(eaddr_width_p, btb_indx_width_p, bht_indx_width_p, ras_addr_width_p)

   localparam int unsigned entry_width_lp = $bits(bp_fe_bp_update_s);

   bp_fe_bp_update_s        wr_entry;
   bp_fe_bp_update_s        rd_entry;
   logic [ptr_width_lp-1:0] rd_ptr;
   logic [ptr_width_lp-1:0] wr_ptr;
   logic [cnt_width_lp-1:0] count;
   logic                    empty;
   logic                    full;
   logic                    bypass;
   logic                    push;
   logic                    pop;

   // Pack incoming update into an entry.
   always_comb begin
      wr_entry          = '0;
      wr_entry.attaboy  = bus.upd_attaboy_i;
      wr_entry.target   = bus.upd_target_i;
      wr_entry.metadata = bus.upd_metadata_i;
   end

   assign empty = (count == '0);
   assign full  = (count == cnt_width_lp'(els_p));

`ifdef BP_FE_BP_UPDATE_BYPASS_EN
   assign bypass = empty & bus.drain_en_i & bus.upd_v_i & ~flush_i;
`else
   assign bypass = 1'b0;
`endif

   // A full queue never accepts, even when popping the same cycle; flush drops everything.
   assign bus.upd_ready_o = ~full;
   assign push            = bus.upd_v_i & ~full & ~flush_i & ~bypass;
   assign pop             = ~empty & bus.drain_en_i & ~flush_i;
   assign count_o         = count;

   // Pointer and occupancy state.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush_i) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + ptr_width_lp'(1);
         if (pop)  rd_ptr <= rd_ptr + ptr_width_lp'(1);
         count <= count + cnt_width_lp'(push) - cnt_width_lp'(pop);
      end
   end

   bp_fe_bp_update_mem #(
      .els_p   (els_p),
      .width_p (entry_width_lp)
   ) mem (
      .clk_i    (clk_i),
      .w_v_i    (push),
      .w_addr_i (wr_ptr),
      .w_data_i (wr_entry),
      .r_addr_i (rd_ptr),
      .r_data_o (rd_entry)
   );

   // Predictor write port: bypassed input when empty, else queue head; zero when idle.
   always_comb begin
      bus.w_v_o                 = 1'b0;
      bus.attaboy_o             = 1'b0;
      bus.pc_cmd_o              = '0;
      bus.branch_metadata_fwd_o = '0;
      if (bypass) begin
         bus.w_v_o                 = 1'b1;
         bus.attaboy_o             = wr_entry.attaboy;
         bus.pc_cmd_o              = wr_entry.target;
         bus.branch_metadata_fwd_o = wr_entry.metadata;
      end else if (!empty) begin
         bus.w_v_o                 = pop;
         bus.attaboy_o             = rd_entry.attaboy;
         bus.pc_cmd_o              = rd_entry.target;
         bus.branch_metadata_fwd_o = rd_entry.metadata;
      end
   end

endmodule

// File: tb/tb_bp_fe_bp_update_queue.sv
// Directed testbench for bp_fe_bp_update_queue; bypass expectations follow BP_FE_BP_UPDATE_BYPASS_EN.

module tb_bp_fe_bp_update_queue;

   localparam int unsigned EW = 39;
   localparam int unsigned MW = 16;
   localparam int unsigned CW = 3;

   logic clk;
   logic rst_n;
   logic flush;
   logic [CW-1:0] count;

   int n_checks;
   int n_fail;

   bp_fe_bp_update_queue_if #(.eaddr_width_p(EW), .mdata_width_p(MW)) bus ();

   bp_fe_bp_update_queue #(
      .eaddr_width_p    (EW),
      .btb_indx_width_p (9),
      .bht_indx_width_p (5),
      .ras_addr_width_p (2),
      .els_p            (4)
   ) dut (
      .clk_i     (clk),
      .reset_n_i (rst_n),
      .flush_i   (flush),
      .bus       (bus),
      .count_o   (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      flush = 1'b0;
      bus.upd_v_i = 1'b0;
      bus.upd_attaboy_i = 1'b0;
      bus.upd_target_i = '0;
      bus.upd_metadata_i = '0;
      bus.drain_en_i = 1'b0;
      #12;
      n_checks++; if (count !== CW'(0)) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
      n_checks++; if (bus.w_v_o !== 1'b0) begin n_fail++; $display("FAIL reset_wv: got %b expected 0", bus.w_v_o); end
      n_checks++; if (bus.pc_cmd_o !== EW'(0)) begin n_fail++; $display("FAIL reset_pc: got %0h expected 0", bus.pc_cmd_o); end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         next_cycle();
         mid();
         n_checks++; if (bus.w_v_o !== 1'b0) begin n_fail++; $display("FAIL idle_wv[%0d]: got %b expected 0", i, bus.w_v_o); end
         n_checks++; if (count !== CW'(0)) begin n_fail++; $display("FAIL idle_count[%0d]: got %0d expected 0", i, count); end
         n_checks++; if (bus.upd_ready_o !== 1'b1) begin n_fail++; $display("FAIL idle_ready[%0d]: got %b expected 1", i, bus.upd_ready_o); end
      end
   endtask

   task automatic test_fill_and_drain();
      logic [EW-1:0] exp_pc;
      bus.drain_en_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         next_cycle();
         bus.upd_v_i = 1'b1;
         bus.upd_target_i = EW'(32'h100 * (i + 1));
         bus.upd_metadata_i = MW'(i + 1);
         bus.upd_attaboy_i = i[0];
         mid();
         n_checks++; if (bus.upd_ready_o !== 1'b1) begin n_fail++; $display("FAIL fill_ready[%0d]: got %b expected 1", i, bus.upd_ready_o); end
         n_checks++; if (count !== CW'(i)) begin n_fail++; $display("FAIL fill_count[%0d]: got %0d expected %0d", i, count, i); end
      end
      // fifth update is offered while full and must be refused
      for (int k = 0; k < 2; k++) begin
         next_cycle();
         bus.upd_v_i = 1'b1;
         bus.upd_target_i = EW'(32'h500);
         mid();
         n_checks++; if (count !== CW'(4)) begin n_fail++; $display("FAIL full_count[%0d]: got %0d expected 4", k, count); end
         n_checks++; if (bus.upd_ready_o !== 1'b0) begin n_fail++; $display("FAIL full_ready[%0d]: got %b expected 0", k, bus.upd_ready_o); end
         n_checks++; if (bus.w_v_o !== 1'b0) begin n_fail++; $display("FAIL full_wv[%0d]: got %b expected 0", k, bus.w_v_o); end
      end
      for (int i = 0; i < 4; i++) begin
         next_cycle();
         bus.upd_v_i = 1'b0;
         bus.drain_en_i = 1'b1;
         mid();
         exp_pc = EW'(32'h100 * (i + 1));
         n_checks++; if (bus.w_v_o !== 1'b1) begin n_fail++; $display("FAIL drain_wv[%0d]: got %b expected 1", i, bus.w_v_o); end
         n_checks++; if (bus.pc_cmd_o !== exp_pc) begin n_fail++; $display("FAIL drain_pc[%0d]: got %0h expected %0h", i, bus.pc_cmd_o, exp_pc); end
         n_checks++; if (bus.branch_metadata_fwd_o !== MW'(i + 1)) begin n_fail++; $display("FAIL drain_md[%0d]: got %0h expected %0h", i, bus.branch_metadata_fwd_o, i + 1); end
         n_checks++; if (bus.attaboy_o !== i[0]) begin n_fail++; $display("FAIL drain_attaboy[%0d]: got %b expected %b", i, bus.attaboy_o, i[0]); end
         n_checks++; if (count !== CW'(4 - i)) begin n_fail++; $display("FAIL drain_count[%0d]: got %0d expected %0d", i, count, 4 - i); end
      end
      next_cycle();
      mid();
      n_checks++; if (bus.w_v_o !== 1'b0) begin n_fail++; $display("FAIL drained_wv: got %b expected 0", bus.w_v_o); end
      n_checks++; if (count !== CW'(0)) begin n_fail++; $display("FAIL drained_count: got %0d expected 0", count); end
      n_checks++; if (bus.pc_cmd_o !== EW'(0)) begin n_fail++; $display("FAIL drained_pc: got %0h expected 0", bus.pc_cmd_o); end
      bus.drain_en_i = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [EW-1:0] exp_pc;
      bus.drain_en_i = 1'b0;
      for (int i = 0; i < 2; i++) begin
         next_cycle();
         bus.upd_v_i = 1'b1;
         bus.upd_target_i = EW'(32'h1000 + i);
         mid();
      end
      for (int i = 0; i < 20; i++) begin
         next_cycle();
         bus.upd_v_i = 1'b1;
         bus.drain_en_i = 1'b1;
         bus.upd_target_i = EW'(32'h1002 + i);
         mid();
         exp_pc = EW'(32'h1000 + i);
         n_checks++; if (count !== CW'(2)) begin n_fail++; $display("FAIL stream_count[%0d]: got %0d expected 2", i, count); end
         n_checks++; if (bus.w_v_o !== 1'b1) begin n_fail++; $display("FAIL stream_wv[%0d]: got %b expected 1", i, bus.w_v_o); end
         n_checks++; if (bus.pc_cmd_o !== exp_pc) begin n_fail++; $display("FAIL stream_pc[%0d]: got %0h expected %0h", i, bus.pc_cmd_o, exp_pc); end
      end
      for (int i = 0; i < 2; i++) begin
         next_cycle();
         bus.upd_v_i = 1'b0;
         mid();
         exp_pc = EW'(32'h1014 + i);
         n_checks++; if (bus.pc_cmd_o !== exp_pc) begin n_fail++; $display("FAIL stream_tail_pc[%0d]: got %0h expected %0h", i, bus.pc_cmd_o, exp_pc); end
      end
      next_cycle();
      bus.drain_en_i = 1'b0;
      mid();
      n_checks++; if (count !== CW'(0)) begin n_fail++; $display("FAIL stream_end_count: got %0d expected 0", count); end
   endtask

   task automatic test_flush();
      bus.drain_en_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         next_cycle();
         bus.upd_v_i = 1'b1;
         bus.upd_target_i = EW'(32'h2000 + i);
         mid();
      end
      next_cycle();
      bus.upd_v_i = 1'b1;
      bus.upd_target_i = EW'(32'h3000);
      bus.drain_en_i = 1'b1;
      flush = 1'b1;
      mid();
      n_checks++; if (bus.w_v_o !== 1'b0) begin n_fail++; $display("FAIL flush_cycle_wv: got %b expected 0", bus.w_v_o); end
      n_checks++; if (count !== CW'(3)) begin n_fail++; $display("FAIL flush_cycle_count: got %0d expected 3", count); end
      next_cycle();
      flush = 1'b0;
      bus.upd_v_i = 1'b0;
      mid();
      n_checks++; if (count !== CW'(0)) begin n_fail++; $display("FAIL flushed_count: got %0d expected 0", count); end
      n_checks++; if (bus.w_v_o !== 1'b0) begin n_fail++; $display("FAIL flushed_wv: got %b expected 0", bus.w_v_o); end
      n_checks++; if (bus.pc_cmd_o !== EW'(0)) begin n_fail++; $display("FAIL flushed_pc: got %0h expected 0", bus.pc_cmd_o); end
      next_cycle();
      bus.drain_en_i = 1'b0;
      bus.upd_v_i = 1'b1;
      bus.upd_target_i = EW'(32'hABC);
      mid();
      next_cycle();
      bus.upd_v_i = 1'b0;
      bus.drain_en_i = 1'b1;
      mid();
      n_checks++; if (bus.pc_cmd_o !== EW'(32'hABC)) begin n_fail++; $display("FAIL post_flush_pc: got %0h expected abc", bus.pc_cmd_o); end
      n_checks++; if (count !== CW'(1)) begin n_fail++; $display("FAIL post_flush_count: got %0d expected 1", count); end
      n_checks++; if (bus.w_v_o !== 1'b1) begin n_fail++; $display("FAIL post_flush_wv: got %b expected 1", bus.w_v_o); end
      next_cycle();
      bus.drain_en_i = 1'b0;
      mid();
      n_checks++; if (count !== CW'(0)) begin n_fail++; $display("FAIL post_flush_end_count: got %0d expected 0", count); end
   endtask

   task automatic test_reset_mid_drain();
      bus.drain_en_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         next_cycle();
         bus.upd_v_i = 1'b1;
         bus.upd_target_i = EW'(32'h4000 + i);
         mid();
      end
      next_cycle();
      bus.upd_v_i = 1'b0;
      bus.drain_en_i = 1'b1;
      mid();
      n_checks++; if (bus.w_v_o !== 1'b1) begin n_fail++; $display("FAIL pre_reset_wv: got %b expected 1", bus.w_v_o); end
      n_checks++; if (count !== CW'(3)) begin n_fail++; $display("FAIL pre_reset_count: got %0d expected 3", count); end
      n_checks++; if (bus.pc_cmd_o !== EW'(32'h4000)) begin n_fail++; $display("FAIL pre_reset_pc: got %0h expected 4000", bus.pc_cmd_o); end
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++; if (bus.w_v_o !== 1'b0) begin n_fail++; $display("FAIL async_reset_wv: got %b expected 0", bus.w_v_o); end
      n_checks++; if (count !== CW'(0)) begin n_fail++; $display("FAIL async_reset_count: got %0d expected 0", count); end
      n_checks++; if (bus.pc_cmd_o !== EW'(0)) begin n_fail++; $display("FAIL async_reset_pc: got %0h expected 0", bus.pc_cmd_o); end
      @(negedge clk);
      rst_n = 1'b1;
      next_cycle();
      mid();
      n_checks++; if (count !== CW'(0)) begin n_fail++; $display("FAIL post_reset_count: got %0d expected 0", count); end
      n_checks++; if (bus.w_v_o !== 1'b0) begin n_fail++; $display("FAIL post_reset_wv: got %b expected 0", bus.w_v_o); end
      bus.drain_en_i = 1'b0;
   endtask

   task automatic test_bypass();
      next_cycle();
      bus.drain_en_i = 1'b1;
      bus.upd_v_i = 1'b1;
      bus.upd_attaboy_i = 1'b1;
      bus.upd_target_i = EW'(32'h7A0);
      bus.upd_metadata_i = MW'(16'h2C5);
      mid();
`ifdef BP_FE_BP_UPDATE_BYPASS_EN
      n_checks++; if (bus.w_v_o !== 1'b1) begin n_fail++; $display("FAIL bypass_wv: got %b expected 1", bus.w_v_o); end
      n_checks++; if (bus.pc_cmd_o !== EW'(32'h7A0)) begin n_fail++; $display("FAIL bypass_pc: got %0h expected 7a0", bus.pc_cmd_o); end
      n_checks++; if (bus.branch_metadata_fwd_o !== MW'(16'h2C5)) begin n_fail++; $display("FAIL bypass_md: got %0h expected 2c5", bus.branch_metadata_fwd_o); end
      n_checks++; if (count !== CW'(0)) begin n_fail++; $display("FAIL bypass_count: got %0d expected 0", count); end
      next_cycle();
      bus.upd_v_i = 1'b0;
      mid();
      n_checks++; if (count !== CW'(0)) begin n_fail++; $display("FAIL bypass_after_count: got %0d expected 0", count); end
      n_checks++; if (bus.w_v_o !== 1'b0) begin n_fail++; $display("FAIL bypass_after_wv: got %b expected 0", bus.w_v_o); end
`else
      n_checks++; if (bus.w_v_o !== 1'b0) begin n_fail++; $display("FAIL nobypass_wv0: got %b expected 0", bus.w_v_o); end
      n_checks++; if (bus.pc_cmd_o !== EW'(0)) begin n_fail++; $display("FAIL nobypass_pc0: got %0h expected 0", bus.pc_cmd_o); end
      n_checks++; if (count !== CW'(0)) begin n_fail++; $display("FAIL nobypass_count0: got %0d expected 0", count); end
      next_cycle();
      bus.upd_v_i = 1'b0;
      mid();
      n_checks++; if (bus.w_v_o !== 1'b1) begin n_fail++; $display("FAIL nobypass_wv1: got %b expected 1", bus.w_v_o); end
      n_checks++; if (bus.pc_cmd_o !== EW'(32'h7A0)) begin n_fail++; $display("FAIL nobypass_pc1: got %0h expected 7a0", bus.pc_cmd_o); end
      n_checks++; if (bus.branch_metadata_fwd_o !== MW'(16'h2C5)) begin n_fail++; $display("FAIL nobypass_md1: got %0h expected 2c5", bus.branch_metadata_fwd_o); end
      n_checks++; if (bus.attaboy_o !== 1'b1) begin n_fail++; $display("FAIL nobypass_attaboy1: got %b expected 1", bus.attaboy_o); end
      n_checks++; if (count !== CW'(1)) begin n_fail++; $display("FAIL nobypass_count1: got %0d expected 1", count); end
      next_cycle();
      mid();
      n_checks++; if (count !== CW'(0)) begin n_fail++; $display("FAIL nobypass_count2: got %0d expected 0", count); end
      n_checks++; if (bus.w_v_o !== 1'b0) begin n_fail++; $display("FAIL nobypass_wv2: got %b expected 0", bus.w_v_o); end
`endif
      bus.drain_en_i = 1'b0;
   endtask

   initial begin
      n_checks = 0;
      n_fail = 0;
      test_reset();
      test_fill_and_drain();
      test_back_to_back();
      test_flush();
      test_reset_mid_drain();
      test_bypass();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
